// File: rtl/mips_cache_pkg.sv
// mips_cache_pkg: shared types, default geometry and address-field widths for the data cache
package mips_cache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_e;
  localparam int DEF_LINES = 8;
  localparam int DEF_WORDS = 4;
  localparam int WORD_W = 16;
  function automatic int ob_w(input int words);
    return $clog2(words);
  endfunction
  function automatic int ib_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines, input int words);
    return WORD_W - $clog2(lines) - $clog2(words);
  endfunction
endpackage

// File: rtl/cache_data_array.sv
// cache_data_array: LINES x WORDS x 16-bit storage, one synchronous write port, one asynchronous read port
module cache_data_array
  import mips_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ib_w(LINES)-1:0]   widx,
  input  logic [ob_w(WORDS)-1:0]   woff,
  input  logic [WORD_W-1:0]        wdata,
  input  logic [ib_w(LINES)-1:0]   ridx,
  input  logic [ob_w(WORDS)-1:0]   roff,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] data_q [LINES][WORDS];
  // store one word per write strobe; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) data_q[widx][woff] <= wdata;
  end
  assign rdata = data_q[ridx][roff];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl
  import mips_cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  cpu_addr,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic               hit,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WORD_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  input  logic [WORD_W-1:0]  mem_rdata,
  input  logic               mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);
  localparam int OB = ob_w(WORDS);
  localparam int IB = ib_w(LINES);
  localparam int TW = tag_w(LINES, WORDS);

  logic [OB-1:0]     off;
  logic [IB-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [IB-1:0]     fidx;
  state_e            state_q, state_d;
  logic [OB-1:0]     beat_q, beat_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tags_q [LINES];
  logic [TW-1:0]     tags_d [LINES];
  logic              line_hit;
  logic              arr_we;
  logic [IB-1:0]     arr_widx;
  logic [OB-1:0]     arr_woff;
  logic [WORD_W-1:0] arr_wdata, arr_rdata;

  assign off      = cpu_addr[OB-1:0];
  assign idx      = cpu_addr[OB+IB-1:OB];
  assign tag      = cpu_addr[WORD_W-1:OB+IB];
  assign fidx     = addr_q[OB+IB-1:OB];
  assign line_hit = valid_q[idx] && (tags_q[idx] == tag);

  cache_data_array #(.LINES(LINES), .WORDS(WORDS)) u_data (
    .clk   (clk),
    .we    (arr_we && rst_n),
    .widx  (arr_widx),
    .woff  (arr_woff),
    .wdata (arr_wdata),
    .ridx  (idx),
    .roff  (off),
    .rdata (arr_rdata)
  );

  // next-state, memory-port and pipeline outputs; every output defaults to its idle value
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    valid_d   = valid_q;
    tags_d    = tags_q;
    hit       = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_widx  = idx;
    arr_woff  = off;
    arr_wdata = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          arr_we  = line_hit;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = WRITE;
        end else if (cpu_read && line_hit) begin
          hit       = 1'b1;
          cpu_rdata = arr_rdata;
        end else if (cpu_read) begin
          addr_d  = cpu_addr;
          beat_d  = '0;
          state_d = FILL;
        end else begin
          hit = 1'b1;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[WORD_W-1:OB], beat_q};
        if (mem_ack) begin
          arr_we    = 1'b1;
          arr_widx  = fidx;
          arr_woff  = beat_q;
          arr_wdata = mem_rdata;
          beat_d    = beat_q + 1'b1;
          if (&beat_q) begin
            valid_d[fidx] = 1'b1;
            tags_d[fidx]  = addr_q[WORD_W-1:OB+IB];
            state_d       = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = mem_ack ? WDONE : WRITE;
      end
      default: begin
        hit     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // controller state, latches and tag/valid store; a reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      tags_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      tags_q  <= tags_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        rd_lookup;
  assign rd_lookup = (state_q == IDLE) && cpu_read && !cpu_write;

  // saturating counters of read lookups made in IDLE
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {15'd0, rd_lookup && line_hit && !(&hit_cnt_q)};
    miss_cnt_d = miss_cnt_q + {15'd0, rd_lookup && !line_hit && !(&miss_cnt_q)};
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven, hand-sequenced and randomized checks of dcache_ctrl against a behavioural cache model
module tb_dcache_ctrl;
  localparam int LINES = 8;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, hit;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory device contents (written by the DUT) and the reference memory (written by the bench's intent)
  logic [15:0] mem_aa [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] rd_q[$], wa_q[$], wd_q[$];
  int          wait_n = 0;
  bit          force_ack = 1'b0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return mem_aa.exists(a) ? mem_aa[a] : a;
  endfunction

  function automatic logic [15:0] ref_val(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a;
  endfunction

  // memory responder: wait_n idle cycles per request, then a one-cycle ack
  initial begin
    int          wcnt;
    bit          in_req;
    logic [15:0] a0;
    logic [16:0] d0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wcnt = 0;
    in_req = 1'b0;
    a0 = '0;
    d0 = '0;
    forever begin
      @(negedge clk);
      mem_ack = force_ack;
      if (!mem_req) begin
        in_req = 1'b0;
        wcnt = 0;
      end else begin
        if (!in_req) begin
          in_req = 1'b1;
          wcnt = 0;
          a0 = mem_addr;
          d0 = {mem_we, mem_wdata};
        end
        if (wcnt < wait_n) wcnt++;
        else begin
          chk("mem_port_stable", {mem_addr, mem_we, mem_wdata}, {a0, d0});
          mem_ack = 1'b1;
          in_req = 1'b0;
          wcnt = 0;
          if (mem_we) begin
            mem_aa[mem_addr] = mem_wdata;
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_val(mem_addr);
            rd_q.push_back(mem_addr);
          end
        end
      end
    end
  end

  // behavioural cache model: which memory block each line currently mirrors
  bit mv[LINES];
  int mt[LINES];

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    wait_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // present one access at a negedge, count cycles with hit=0, capture at the first negedge with hit=1
  task automatic check_access(input string nm, input logic [15:0] a, input bit w, input logic [15:0] wd,
                              input int wt, input int est, input logic [15:0] erd, input int enf,
                              input logic [15:0] efb);
    int st;
    int l;
    wait_n = wt;
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    @(negedge clk);
    cpu_addr = a;
    cpu_write = w;
    cpu_read = !w;
    cpu_wdata = wd;
    #1;
    st = hit ? 0 : 1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (hit) break;
      st++;
    end
    chk({nm, "_done"}, hit, 1);
    chk({nm, "_stall"}, st, est);
    chk({nm, "_rdata"}, cpu_rdata, erd);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    chk({nm, "_nfill"}, rd_q.size(), enf);
    for (int i = 0; i < rd_q.size(); i++) chk({nm, "_fill_addr"}, rd_q[i], 16'(efb + i));
    chk({nm, "_nwrite"}, wa_q.size(), w ? 1 : 0);
    for (int i = 0; i < wa_q.size(); i++) begin
      chk({nm, "_wr_addr"}, wa_q[i], a);
      chk({nm, "_wr_data"}, wd_q[i], wd);
    end
    l = (a / WORDS) % LINES;
    if (w) ref_mem[a] = wd;
    else begin
      mv[l] = 1'b1;
      mt[l] = a / (WORDS * LINES);
    end
    @(negedge clk);
  endtask

  // derive the expected result of an access from the cache rules and run it
  task automatic model_access(input string nm, input logic [15:0] a, input bit w, input logic [15:0] wd, input int wt);
    int  l;
    bit  h;
    l = (a / WORDS) % LINES;
    h = !w && mv[l] && (mt[l] == a / (WORDS * LINES));
    check_access(nm, a, w, wd, wt,
                 w ? 2 + wt : (h ? 0 : 1 + WORDS * (wt + 1)),
                 w ? 16'h0 : ref_val(a),
                 (w || h) ? 0 : WORDS,
                 a - (a % WORDS));
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic        w;
    logic [15:0] wd;
    int          wt;
    int          st;
    logic [15:0] rd;
    int          nf;
    logic [15:0] fb;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{16'h0013, 1'b0, 16'h0000, 0, 5,  16'h0013, 4, 16'h0010};
    tbl[1]  = '{16'h0011, 1'b0, 16'h0000, 0, 0,  16'h0011, 0, 16'h0000};
    tbl[2]  = '{16'h0033, 1'b0, 16'h0000, 0, 5,  16'h0033, 4, 16'h0030};
    tbl[3]  = '{16'h0013, 1'b0, 16'h0000, 0, 5,  16'h0013, 4, 16'h0010};
    tbl[4]  = '{16'h0012, 1'b1, 16'hBEEF, 0, 2,  16'h0000, 0, 16'h0000};
    tbl[5]  = '{16'h0012, 1'b0, 16'h0000, 0, 0,  16'hBEEF, 0, 16'h0000};
    tbl[6]  = '{16'h0105, 1'b1, 16'h1234, 0, 2,  16'h0000, 0, 16'h0000};
    tbl[7]  = '{16'h0105, 1'b0, 16'h0000, 0, 5,  16'h1234, 4, 16'h0104};
    tbl[8]  = '{16'h0053, 1'b0, 16'h0000, 3, 17, 16'h0053, 4, 16'h0050};
    tbl[9]  = '{16'h0053, 1'b1, 16'h5555, 3, 5,  16'h0000, 0, 16'h0000};
    tbl[10] = '{16'h0053, 1'b0, 16'h0000, 0, 0,  16'h5555, 0, 16'h0000};
    tbl[11] = '{16'h0010, 1'b0, 16'h0000, 2, 13, 16'h0010, 4, 16'h0010};

    do_reset();
    #1;
    chk("rst_hit", hit, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);

    for (int i = 0; i < 12; i++)
      check_access($sformatf("v%0d", i), tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].wt,
                   tbl[i].st, tbl[i].rd, tbl[i].nf, tbl[i].fb);

    // reset in the middle of a fill, then stray acks, then a full refill from beat 0
    wait_n = 1;
    rd_q.delete();
    @(negedge clk);
    cpu_addr = 16'h0077;
    cpu_read = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (rd_q.size() >= 3) break;
    end
    chk("rst_fill_beats_seen", rd_q.size(), 3);
    rst_n = 1'b0;
    cpu_read = 1'b0;
    @(posedge clk);
    #1;
    chk("midfill_rst_req", mem_req, 0);
    chk("midfill_rst_hit", hit, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n = 0;
    #1;
    force_ack = 1'b1;
    @(negedge clk);
    #1;
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("stray_ack_hit", hit, 1);
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_addr", mem_addr, 0);
    model_reset();
    model_access("rst_refill", 16'h0077, 1'b0, 16'h0, 0);

`ifdef DCACHE_STATS_EN
    do_reset();
    #1;
    chk("cnt_rst_hit", hit_count, 0);
    chk("cnt_rst_miss", miss_count, 0);
    model_access("st_m1", 16'h0013, 1'b0, 16'h0, 0);
    model_access("st_h1", 16'h0011, 1'b0, 16'h0, 0);
    model_access("st_h2", 16'h0012, 1'b0, 16'h0, 0);
    model_access("st_wr", 16'h0011, 1'b1, 16'h7777, 0);
    model_access("st_m2", 16'h0033, 1'b0, 16'h0, 1);
    model_access("st_h3", 16'h0030, 1'b0, 16'h0, 0);
    chk("cnt_hit", hit_count, 3);
    chk("cnt_miss", miss_count, 2);
    @(negedge clk);
    cpu_addr = 16'h0031;
    cpu_read = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (hit_count == 16'hFFFF) break;
    end
    repeat (4) @(negedge clk);
    cpu_read = 1'b0;
    chk("cnt_hit_sat", hit_count, 16'hFFFF);
    chk("cnt_miss_hold", miss_count, 2);
`endif

    do_reset();
    for (int n = 0; n < 150; n++)
      model_access($sformatf("r%0d", n), 16'($urandom_range(0, 127)), ($urandom_range(0, 9) < 3),
                   16'($urandom), $urandom_range(0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
